// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers hex digits from a multiplexed, active-low
// 7-segment bus. Each digit pattern must be stable for STABLE_CYCLES samples
// before it is decoded into its slot; a complete set of slots is published
// as one frame with a single-cycle strobe.
module seg7_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     dig_n,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     digit_ok,
    output logic                  frame_err,
    output logic                  frame_stb
);

    localparam int SW = 7 + DIGITS;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 1);

    logic [SW-1:0]     s_q;
    logic [CW-1:0]     cnt;
    logic [DIGITS-1:0] seen;
    logic [DIGITS-1:0] seen_next;
    logic [3:0]        slot [DIGITS];
    logic [DIGITS-1:0] slot_ok;

    logic [SW-1:0]     sample;
    logic              same;
    logic              capture;
    logic [DIGITS-1:0] dig_low;
    logic              one_hot;
    logic              cap_valid;
    logic              frame_done;
    logic [3:0]        nib;
    logic              nib_ok;

    assign sample     = {seg_n, dig_n};
    assign same       = (sample == s_q);
    // Fires exactly once per stable period, on the cnt STABLE-1 -> STABLE edge.
    assign capture    = same && (cnt == CNT_PRE);
    assign dig_low    = ~s_q[DIGITS-1:0];
    assign one_hot    = (dig_low != '0) && ((dig_low & (dig_low - 1'b1)) == '0);
    assign cap_valid  = capture && one_hot;
    assign frame_done = &seen;

    // Sample register and saturating stability counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q <= '1;
            cnt <= '0;
        end else if (!same) begin
            s_q <= sample;
            cnt <= CW'(1);
        end else if (cnt < CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Inverse of the hex-to-segment table; s_q already equals the input on a capture edge.
    always_comb begin
        nib    = 4'h0;
        nib_ok = 1'b1;
        case (s_q[SW-1:DIGITS])
            7'b1000000: nib = 4'h0;
            7'b1111001: nib = 4'h1;
            7'b0100100: nib = 4'h2;
            7'b0110000: nib = 4'h3;
            7'b0011001: nib = 4'h4;
            7'b0010010: nib = 4'h5;
            7'b0000010: nib = 4'h6;
            7'b1111000: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0010000: nib = 4'h9;
            7'b0001000: nib = 4'hA;
            7'b0000011: nib = 4'hB;
            7'b1000110: nib = 4'hC;
            7'b0100001: nib = 4'hD;
            7'b0000110: nib = 4'hE;
            7'b0001110: nib = 4'hF;
            default: begin
                nib    = 4'h0;
                nib_ok = 1'b0;
            end
        endcase
    end

    // Frame completion clears seen first, so a capture on that same edge survives.
    always_comb begin
        seen_next = frame_done ? '0 : seen;
        if (cap_valid) begin
            seen_next = seen_next | dig_low;
        end
    end

    // Slot storage and seen tracking; the latest capture for a slot wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen    <= '0;
            slot_ok <= '0;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                slot[i] <= '0;
            end
        end else begin
            seen <= seen_next;
            if (cap_valid) begin
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    if (dig_low[i]) begin
                        slot[i]    <= nib;
                        slot_ok[i] <= nib_ok;
                    end
                end
            end
        end
    end

    // Publish the assembled frame on the edge after every slot has been seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value     <= '0;
            digit_ok  <= '0;
            frame_err <= 1'b0;
            frame_stb <= 1'b0;
        end else begin
            frame_stb <= frame_done;
            if (frame_done) begin
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    value[4*i +: 4] <= slot[i];
                end
                digit_ok  <= slot_ok;
                frame_err <= ~&slot_ok;
            end
        end
    end

endmodule
